trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and MRET from EX,
// issues the CSR write sequence, then a single-cycle PC redirect.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        exc_valid,
  input  logic [30:0] exc_cause,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        flush_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    W_MSTATUS,
    M_MSTATUS,
    REDIRECT
  } state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  state_t      state;
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [29:0] mepc_q;

  logic        take_ext;
  logic        take_sw;
  logic        take_tim;
  logic        irq_take;
  logic [4:0]  irq_code;
  logic        accept;
  logic        is_trap;
  logic [31:0] acc_cause;
  logic [31:0] acc_tval;
  logic        vec_hit;
  logic [31:0] trap_target;
  logic        unused_ok;

  function automatic logic [31:0] trap_ms(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_ms(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  assign take_ext = mstatus_i[3] & irq_ext   & mie_i[11];
  assign take_sw  = mstatus_i[3] & irq_sw    & mie_i[3];
  assign take_tim = mstatus_i[3] & irq_timer & mie_i[7];
  assign irq_take = take_ext | take_sw | take_tim;

  always_comb begin
    irq_code = 5'd0;
    if (take_ext)      irq_code = 5'd11;
    else if (take_sw)  irq_code = 5'd3;
    else if (take_tim) irq_code = 5'd7;
  end

  assign accept = rst_n & (state == IDLE) & ex_valid
                & (exc_valid | irq_take | mret_valid);
  assign is_trap = exc_valid | irq_take;

  assign acc_cause = exc_valid ? {1'b0, exc_cause}
                               : {1'b1, 26'd0, irq_code};
  assign acc_tval  = exc_valid ? exc_tval : 32'd0;

  // Vector offset only for interrupts in vectored mode
  assign vec_hit = VECTORED_EN & cause_q[31]
                 & (mtvec_q[1:0] == 2'b01);
  assign trap_target = {mtvec_q[31:2], 2'b00}
                     + (vec_hit ? {cause_q[29:0], 2'b00} : 32'd0);

  assign busy_o  = (state != IDLE);
  assign flush_o = accept | busy_o;

  assign unused_ok = ^{ex_pc[1:0], mepc_i[1:0], mie_i[31:12],
                       mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cause_q        <= '0;
      tval_q         <= '0;
      mstatus_q      <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cause_q   <= acc_cause;
            tval_q    <= acc_tval;
            mstatus_q <= mstatus_i;
            mtvec_q   <= mtvec_i;
            mepc_q    <= mepc_i[31:2];
            csr_we    <= 1'b1;
            if (is_trap) begin
              state     <= W_MEPC;
              csr_waddr <= A_MEPC;
              csr_wdata <= {ex_pc[31:2], 2'b00};
            end else begin
              state     <= M_MSTATUS;
              csr_waddr <= A_MSTATUS;
              csr_wdata <= mret_ms(mstatus_i);
            end
          end
        end
        W_MEPC: begin
          state     <= W_MCAUSE;
          csr_we    <= 1'b1;
          csr_waddr <= A_MCAUSE;
          csr_wdata <= cause_q;
        end
        W_MCAUSE: begin
          state     <= W_MTVAL;
          csr_we    <= 1'b1;
          csr_waddr <= A_MTVAL;
          csr_wdata <= tval_q;
        end
        W_MTVAL: begin
          state     <= W_MSTATUS;
          csr_we    <= 1'b1;
          csr_waddr <= A_MSTATUS;
          csr_wdata <= trap_ms(mstatus_q);
        end
        W_MSTATUS: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
        end
        M_MSTATUS: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= {mepc_q, 2'b00};
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table of trap/MRET/no-op events
// plus hand sequences for busy-ignore and mid-sequence reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        exc_valid;
  logic [30:0] exc_cause;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        irq_ext, irq_sw, irq_timer;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        flush_o;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .mret_valid(mret_valid),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .mstatus_i(mstatus_i), .mie_i(mie_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .flush_o(flush_o), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy_o(busy_o)
  );

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic        exc;
    logic [30:0] cause;
    logic [31:0] tval;
    logic        mret;
    logic        ie, is, it;
    logic [31:0] ms, mie, mtvec, mepc;
    logic [1:0]  kind;
    logic [31:0] e_mepc, e_cause, e_tval, e_ms, e_rpc;
  } vec_t;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_TRAP = 2'd1;
  localparam logic [1:0] K_MRET = 2'd2;

  vec_t v[12];

  task automatic chk(input string nm, input logic we,
                     input logic [11:0] a, input logic [31:0] d,
                     input logic rv, input logic [31:0] rp,
                     input logic bz, input logic fl);
    logic [79:0] act, exp;
    act = {csr_we, csr_waddr, csr_wdata, redirect_valid,
           redirect_pc, busy_o, flush_o};
    exp = {we, a, d, rv, rp, bz, fl};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got we=%b a=%h d=%h rv=%b rp=%h busy=%b fl=%b want we=%b a=%h d=%h rv=%b rp=%h busy=%b fl=%b",
               nm, csr_we, csr_waddr, csr_wdata, redirect_valid,
               redirect_pc, busy_o, flush_o, we, a, d, rv, rp, bz, fl);
    end
  endtask

  task automatic clear_in();
    ex_valid = 0; ex_pc = 0; exc_valid = 0; exc_cause = 0;
    exc_tval = 0; mret_valid = 0;
    irq_ext = 0; irq_sw = 0; irq_timer = 0;
    mstatus_i = 0; mie_i = 0; mtvec_i = 0; mepc_i = 0;
  endtask

  task automatic apply(input vec_t x);
    ex_valid = x.ev; ex_pc = x.pc; exc_valid = x.exc;
    exc_cause = x.cause; exc_tval = x.tval; mret_valid = x.mret;
    irq_ext = x.ie; irq_sw = x.is; irq_timer = x.it;
    mstatus_i = x.ms; mie_i = x.mie; mtvec_i = x.mtvec;
    mepc_i = x.mepc;
  endtask

  // Expected outputs k cycles after the accept cycle
  task automatic chk_step(input string nm, input vec_t x, input int k);
    if (x.kind == K_TRAP) begin
      case (k)
        1: chk(nm, 1, 12'h341, x.e_mepc, 0, 0, 1, 1);
        2: chk(nm, 1, 12'h342, x.e_cause, 0, 0, 1, 1);
        3: chk(nm, 1, 12'h343, x.e_tval, 0, 0, 1, 1);
        4: chk(nm, 1, 12'h300, x.e_ms, 0, 0, 1, 1);
        5: chk(nm, 0, 0, 0, 1, x.e_rpc, 1, 1);
        default: chk(nm, 0, 0, 0, 0, 0, 0, 0);
      endcase
    end else if (x.kind == K_MRET) begin
      case (k)
        1: chk(nm, 1, 12'h300, x.e_ms, 0, 0, 1, 1);
        2: chk(nm, 0, 0, 0, 1, x.e_rpc, 1, 1);
        default: chk(nm, 0, 0, 0, 0, 0, 0, 0);
      endcase
    end else begin
      chk(nm, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // ev pc exc cause tval mret ie is it ms mie mtvec mepc kind
    // e_mepc e_cause e_tval e_ms e_rpc
    v[0]  = '{1'b1, 32'h100, 1'b1, 31'd2, 32'hDEAD, 1'b0,
              1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 32'h200, 32'h0, K_TRAP,
              32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h200};
    v[1]  = '{1'b1, 32'h40, 1'b0, 31'd0, 32'h0, 1'b0,
              1'b0, 1'b0, 1'b1, 32'h8, 32'h80, 32'h201, 32'h0, K_TRAP,
              32'h40, 32'h80000007, 32'h0, 32'h1880, 32'h21C};
    v[2]  = '{1'b1, 32'h60, 1'b0, 31'd0, 32'h0, 1'b0,
              1'b1, 1'b0, 1'b0, 32'h0, 32'h800, 32'h200, 32'h0, K_NONE,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[3]  = '{1'b1, 32'h50, 1'b0, 31'd0, 32'h0, 1'b1,
              1'b0, 1'b0, 1'b0, 32'h1880, 32'h0, 32'h200, 32'h104, K_MRET,
              32'h0, 32'h0, 32'h0, 32'h1888, 32'h104};
    v[4]  = '{1'b1, 32'h200, 1'b1, 31'd5, 32'h33, 1'b0,
              1'b1, 1'b0, 1'b0, 32'h8, 32'h800, 32'h301, 32'h0, K_TRAP,
              32'h200, 32'h5, 32'h33, 32'h1880, 32'h300};
    v[5]  = '{1'b1, 32'h84, 1'b0, 31'd0, 32'h1234, 1'b1,
              1'b0, 1'b1, 1'b0, 32'h8, 32'h8, 32'h401, 32'h999, K_TRAP,
              32'h84, 32'h80000003, 32'h0, 32'h1880, 32'h40C};
    v[6]  = '{1'b0, 32'h100, 1'b1, 31'd2, 32'h1, 1'b1,
              1'b1, 1'b1, 1'b1, 32'h8, 32'h888, 32'h200, 32'h0, K_NONE,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[7]  = '{1'b1, 32'h7, 1'b0, 31'd0, 32'h55, 1'b0,
              1'b1, 1'b1, 1'b1, 32'h8, 32'h888, 32'h1001, 32'h0, K_TRAP,
              32'h4, 32'h8000000B, 32'h0, 32'h1880, 32'h102C};
    v[8]  = '{1'b1, 32'h10, 1'b0, 31'd0, 32'h0, 1'b0,
              1'b0, 1'b1, 1'b1, 32'h88, 32'h88, 32'h2000, 32'h0, K_TRAP,
              32'h10, 32'h80000003, 32'h0, 32'h1880, 32'h2000};
    v[9]  = '{1'b1, 32'h20, 1'b0, 31'd0, 32'h0, 1'b0,
              1'b0, 1'b0, 1'b1, 32'h8, 32'h800, 32'h200, 32'h0, K_NONE,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v[10] = '{1'b1, 32'h30, 1'b0, 31'd0, 32'h0, 1'b1,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h200, 32'h107, K_MRET,
              32'h0, 32'h0, 32'h0, 32'h1880, 32'h104};
    v[11] = '{1'b1, 32'h103, 1'b1, 31'h7FFFFFFF, 32'hFFFFFFFF, 1'b0,
              1'b0, 1'b0, 1'b0, 32'h1800, 32'h0, 32'h201, 32'h0, K_TRAP,
              32'h100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1800, 32'h200};

    // Reset with an event present: everything must stay low
    rst_n = 0;
    clear_in();
    apply(v[0]);
    #1;
    chk("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    clear_in();
    rst_n = 1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(v[i]);
      #1;
      chk($sformatf("v%0d_acc", i), 0, 0, 0, 0, 0, 0, v[i].kind != K_NONE);
      @(posedge clk);
      #1;
      clear_in();
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        chk_step($sformatf("v%0d_k%0d", i, k), v[i], k);
      end
    end

    // Events held during busy must be neither taken nor queued
    @(negedge clk);
    apply(v[0]);
    @(posedge clk);
    #1;
    ex_valid = 1; exc_valid = 1; exc_cause = 31'd9; mret_valid = 1;
    ex_pc = 32'h900; irq_ext = 1; mie_i = 32'h800; mstatus_i = 32'h8;
    mtvec_i = 32'h500; exc_tval = 32'h77;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk_step($sformatf("busy_k%0d", k), v[0], k);
    end
    clear_in();
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk);
      chk_step($sformatf("busy_k%0d", k), v[0], k);
    end

    // Reset while in W_MCAUSE aborts the sequence
    @(negedge clk);
    apply(v[1]);
    @(posedge clk);
    #1;
    clear_in();
    @(negedge clk);
    chk_step("rst_k1", v[1], 1);
    @(negedge clk);
    chk_step("rst_k2", v[1], 2);
    #1;
    rst_n = 0;
    #1;
    chk("rst_async", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after%0d", k), 0, 0, 0, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
